// File: rtl/clk_divider_prog.sv
// Programmable clock divider: glitch-free clkout, period-start tick, load/busy divisor reload.
// Define DIVIDER_SIM_EN to force the effective divisor to 8 (handshake still runs normally).
module clk_divider_prog #(
    parameter int unsigned      WIDTH       = 26,
    parameter logic [WIDTH-1:0] DEFAULT_DIV = WIDTH'(50_000_000)
) (
    input  logic             clkin,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] div_in,
    input  logic             div_load,
    output logic             busy,
    output logic             clkout,
    output logic             tick
);

    logic [WIDTH-1:0] r_div_act;
    logic [WIDTH-1:0] r_div_pend;
    logic [WIDTH-1:0] r_cnt;
    logic             r_busy;
    logic             r_clkout;
    logic             r_tick;

    logic [WIDTH-1:0] w_div_eff;
    logic [WIDTH-1:0] w_half;
    logic [WIDTH-1:0] w_cnt_nxt;
    logic             w_wrap;
    logic             w_apply;

`ifdef DIVIDER_SIM_EN
    assign w_div_eff = WIDTH'(8);
`else
    assign w_div_eff = (r_div_act < WIDTH'(2)) ? WIDTH'(2) : r_div_act;
`endif

    always_comb begin
        w_wrap    = 1'b0;
        w_cnt_nxt = '0;
        w_half    = w_div_eff >> 1;
        if (enable) begin
            w_wrap    = (r_cnt == (w_div_eff - WIDTH'(1)));
            w_cnt_nxt = w_wrap ? '0 : (r_cnt + WIDTH'(1));
        end
        // A new divisor lands only at a period boundary, or immediately while stopped.
        w_apply = r_busy && (w_wrap || !enable);
    end

    // clkout is computed from the next count so it stays aligned with r_cnt;
    // on a wrap the next count is 0, which is below any half-period, so the
    // outgoing divisor is never mixed with the incoming one.
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            r_cnt      <= '0;
            r_clkout   <= 1'b0;
            r_tick     <= 1'b0;
            r_busy     <= 1'b0;
            r_div_act  <= DEFAULT_DIV;
            r_div_pend <= DEFAULT_DIV;
        end else begin
            r_cnt    <= w_cnt_nxt;
            r_clkout <= (w_cnt_nxt >= w_half);
            r_tick   <= w_wrap;
            if (w_apply) begin
                r_div_act <= r_div_pend;
                r_busy    <= 1'b0;
            end
            if (div_load) begin
                r_div_pend <= div_in;
                r_busy     <= 1'b1;
            end
        end
    end

    assign busy   = r_busy;
    assign clkout = r_clkout;
    assign tick   = r_tick;

endmodule

// File: tb/tb_clk_divider_prog.sv
// Directed self-checking bench for clk_divider_prog (default build, DEFAULT_DIV overridden to 6).
module tb_clk_divider_prog;

    localparam int unsigned W = 26;

    logic         clkin    = 1'b0;
    logic         reset    = 1'b1;
    logic         enable   = 1'b0;
    logic         div_load = 1'b0;
    logic [W-1:0] div_in   = '0;
    logic         busy;
    logic         clkout;
    logic         tick;

    int checks   = 0;
    int failures = 0;

    clk_divider_prog #(.WIDTH(W), .DEFAULT_DIV(W'(6))) dut (
        .clkin    (clkin),
        .reset    (reset),
        .enable   (enable),
        .div_in   (div_in),
        .div_load (div_load),
        .busy     (busy),
        .clkout   (clkout),
        .tick     (tick)
    );

    always #5 clkin = ~clkin;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(negedge clkin);
    endtask

    task automatic set_div_stopped(input int d);
        enable   = 1'b0;
        div_in   = W'(d);
        div_load = 1'b1;
        step();
        div_load = 1'b0;
        step();
    endtask

    task automatic test_reset();
        step();
        checks++; if (clkout !== 1'b0) begin failures++; $display("FAIL reset_clkout got=%b exp=0", clkout); end
        checks++; if (tick !== 1'b0)   begin failures++; $display("FAIL reset_tick got=%b exp=0", tick); end
        checks++; if (busy !== 1'b0)   begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        reset = 1'b0;
        step();
        checks++; if (tick !== 1'b0)   begin failures++; $display("FAIL reset_release_tick got=%b exp=0", tick); end
        checks++; if (clkout !== 1'b0) begin failures++; $display("FAIL reset_release_clkout got=%b exp=0", clkout); end
    endtask

    task automatic test_default_div();
        int c;
        logic ec, et;
        enable = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            step();
            c = k % 6; ec = (c >= 3); et = (c == 0);
            checks++; if (clkout !== ec) begin failures++; $display("FAIL def6_clkout k=%0d got=%b exp=%b", k, clkout, ec); end
            checks++; if (tick !== et)   begin failures++; $display("FAIL def6_tick k=%0d got=%b exp=%b", k, tick, et); end
            checks++; if (busy !== 1'b0) begin failures++; $display("FAIL def6_busy k=%0d got=%b exp=0", k, busy); end
        end
    endtask

    task automatic test_div4();
        int c, d;
        logic ec, et, eb;
        enable = 1'b0;
        step();
        enable = 1'b1; div_in = W'(4); div_load = 1'b1;
        for (int k = 1; k <= 18; k++) begin
            step();
            if (k == 1) div_load = 1'b0;
            c  = (k <= 6) ? (k % 6) : ((k - 6) % 4);
            d  = (k < 6) ? 6 : 4;
            ec = (c >= d / 2); et = (c == 0); eb = (k < 6);
            checks++; if (clkout !== ec) begin failures++; $display("FAIL div4_clkout k=%0d got=%b exp=%b", k, clkout, ec); end
            checks++; if (tick !== et)   begin failures++; $display("FAIL div4_tick k=%0d got=%b exp=%b", k, tick, et); end
            checks++; if (busy !== eb)   begin failures++; $display("FAIL div4_busy k=%0d got=%b exp=%b", k, busy, eb); end
        end
    endtask

    task automatic test_div5_div0();
        int c, d;
        logic ec, et, eb;
        enable = 1'b0;
        step();
        enable = 1'b1; div_in = W'(5); div_load = 1'b1;
        for (int k = 1; k <= 19; k++) begin
            step();
            if (k == 1) div_load = 1'b0;
            c  = (k <= 4) ? (k % 4) : ((k - 4) % 5);
            d  = (k < 4) ? 4 : 5;
            ec = (c >= d / 2); et = (c == 0); eb = (k < 4);
            checks++; if (clkout !== ec) begin failures++; $display("FAIL div5_clkout k=%0d got=%b exp=%b", k, clkout, ec); end
            checks++; if (tick !== et)   begin failures++; $display("FAIL div5_tick k=%0d got=%b exp=%b", k, tick, et); end
            checks++; if (busy !== eb)   begin failures++; $display("FAIL div5_busy k=%0d got=%b exp=%b", k, busy, eb); end
        end
        enable = 1'b0;
        step();
        enable = 1'b1; div_in = W'(0); div_load = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            step();
            if (k == 1) div_load = 1'b0;
            c  = (k <= 5) ? (k % 5) : ((k - 5) % 2);
            d  = (k < 5) ? 5 : 2;
            ec = (c >= d / 2); et = (c == 0); eb = (k < 5);
            checks++; if (clkout !== ec) begin failures++; $display("FAIL div0_clkout k=%0d got=%b exp=%b", k, clkout, ec); end
            checks++; if (tick !== et)   begin failures++; $display("FAIL div0_tick k=%0d got=%b exp=%b", k, tick, et); end
            checks++; if (busy !== eb)   begin failures++; $display("FAIL div0_busy k=%0d got=%b exp=%b", k, busy, eb); end
        end
    endtask

    task automatic test_overwrite();
        int c, d;
        logic ec, et, eb;
        set_div_stopped(10);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ovw_stopped_apply_busy got=%b exp=0", busy); end
        enable = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            step();
            if (k == 3) begin div_in = W'(6); div_load = 1'b1; end
            if (k == 4) div_load = 1'b0;
            if (k == 5) begin div_in = W'(7); div_load = 1'b1; end
            if (k == 6) div_load = 1'b0;
            c  = (k <= 10) ? (k % 10) : ((k - 10) % 7);
            d  = (k < 10) ? 10 : 7;
            ec = (c >= d / 2); et = (c == 0); eb = (k >= 4) && (k < 10);
            checks++; if (clkout !== ec) begin failures++; $display("FAIL ovw_clkout k=%0d got=%b exp=%b", k, clkout, ec); end
            checks++; if (tick !== et)   begin failures++; $display("FAIL ovw_tick k=%0d got=%b exp=%b", k, tick, et); end
            checks++; if (busy !== eb)   begin failures++; $display("FAIL ovw_busy k=%0d got=%b exp=%b", k, busy, eb); end
        end
    endtask

    task automatic test_load_at_wrap();
        int c, d;
        logic ec, et, eb;
        enable = 1'b0;
        step();
        enable = 1'b1;
        for (int k = 1; k <= 23; k++) begin
            step();
            if (k == 6) begin div_in = W'(3); div_load = 1'b1; end
            if (k == 7) div_load = 1'b0;
            c  = (k <= 14) ? (k % 7) : ((k - 14) % 3);
            d  = (k < 14) ? 7 : 3;
            ec = (c >= d / 2); et = (c == 0); eb = (k >= 7) && (k < 14);
            checks++; if (clkout !== ec) begin failures++; $display("FAIL wrapload_clkout k=%0d got=%b exp=%b", k, clkout, ec); end
            checks++; if (tick !== et)   begin failures++; $display("FAIL wrapload_tick k=%0d got=%b exp=%b", k, tick, et); end
            checks++; if (busy !== eb)   begin failures++; $display("FAIL wrapload_busy k=%0d got=%b exp=%b", k, busy, eb); end
        end
    endtask

    task automatic test_enable_drop();
        int c;
        logic ec, et, eb;
        set_div_stopped(8);
        enable = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
            if (k == 3) begin div_in = W'(4); div_load = 1'b1; end
            if (k == 4) div_load = 1'b0;
            if (k == 5) enable = 1'b0;
            c  = (k <= 5) ? k : 0;
            ec = (c >= 4); et = 1'b0; eb = (k >= 4) && (k <= 5);
            checks++; if (clkout !== ec) begin failures++; $display("FAIL drop_clkout k=%0d got=%b exp=%b", k, clkout, ec); end
            checks++; if (tick !== et)   begin failures++; $display("FAIL drop_tick k=%0d got=%b exp=%b", k, tick, et); end
            checks++; if (busy !== eb)   begin failures++; $display("FAIL drop_busy k=%0d got=%b exp=%b", k, busy, eb); end
        end
        for (int k = 1; k <= 3; k++) begin
            step();
            checks++; if (clkout !== 1'b0 || tick !== 1'b0) begin
                failures++; $display("FAIL disabled_idle k=%0d got clkout=%b tick=%b exp=0,0", k, clkout, tick);
            end
        end
        enable = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            c  = k % 4; ec = (c >= 2); et = (c == 0);
            checks++; if (clkout !== ec) begin failures++; $display("FAIL reen_clkout k=%0d got=%b exp=%b", k, clkout, ec); end
            checks++; if (tick !== et)   begin failures++; $display("FAIL reen_tick k=%0d got=%b exp=%b", k, tick, et); end
            checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reen_busy k=%0d got=%b exp=0", k, busy); end
        end
    endtask

    task automatic test_reset_mid();
        int c;
        logic ec, et;
        enable = 1'b0;
        step();
        enable = 1'b1;
        step();
        div_in = W'(9); div_load = 1'b1;
        step();
        div_load = 1'b0;
        checks++; if (clkout !== 1'b1 || busy !== 1'b1) begin
            failures++; $display("FAIL prereset_state got clkout=%b busy=%b exp=1,1", clkout, busy);
        end
        #2 reset = 1'b1;
        #1;
        checks++; if (clkout !== 1'b0) begin failures++; $display("FAIL async_reset_clkout got=%b exp=0", clkout); end
        checks++; if (tick !== 1'b0)   begin failures++; $display("FAIL async_reset_tick got=%b exp=0", tick); end
        checks++; if (busy !== 1'b0)   begin failures++; $display("FAIL async_reset_busy got=%b exp=0", busy); end
        step();
        checks++; if (clkout !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL reset_hold got clkout=%b busy=%b exp=0,0", clkout, busy);
        end
        reset = 1'b0;
        for (int k = 1; k <= 13; k++) begin
            step();
            c  = k % 6; ec = (c >= 3); et = (c == 0);
            checks++; if (clkout !== ec) begin failures++; $display("FAIL postreset_clkout k=%0d got=%b exp=%b", k, clkout, ec); end
            checks++; if (tick !== et)   begin failures++; $display("FAIL postreset_tick k=%0d got=%b exp=%b", k, tick, et); end
            checks++; if (busy !== 1'b0) begin failures++; $display("FAIL postreset_busy k=%0d got=%b exp=0", k, busy); end
        end
    endtask

    initial begin
        test_reset();
        test_default_div();
        test_div4();
        test_div5_div0();
        test_overwrite();
        test_load_at_wrap();
        test_enable_drop();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/clk_divider_prog.md
# clk_divider_prog

Programmable, parametrised clock divider generating a glitch-free divided clock plus a one-cycle tick strobe from the board clock. The divisor is reloadable at run time through a load/busy handshake, and new divisors take effect only on a period boundary. It replaces the fixed power-of-two tap divider and feeds slow logic such as display multiplexing, debouncing and visible-rate counters.

## Interface
- `WIDTH`, 26: width of the counter and divisor.
- `DEFAULT_DIV`, 50_000_000: divisor after reset. Must fit in `WIDTH` bits.
- `clkin`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `enable`  in  1  run when high. When low, the counter is held at 0.
- `div_in`  in  WIDTH  new divisor value.
- `div_load`  in  1  single-cycle request to capture `div_in`.
- `busy`  out  1  high while a captured divisor awaits application.
- `clkout`  out  1  divided clock; registered output.
- `tick`  out  1  one-cycle strobe at the start of each period; registered output.

## Operation
- Effective divisor D is taken from the active divisor register `div_act`. Values 0 and 1 are clamped to 2.
- Counter `cnt` counts 0..D-1 while `enable`=1. At D-1 it wraps to 0.
- `clkout` is low while `cnt` < floor(D/2) and high while `cnt` ≥ floor(D/2).
  - It is driven from a flop computed from next-state `cnt`, so it is exactly aligned with `cnt`.
  - Odd D: low for floor(D/2) cycles, high for ceil(D/2) cycles.
- `tick` is 1 in the cycle where `cnt`==0 after a wrap (D-1 → 0). It is never asserted out of reset or out of disable.
- Load handshake:
  - `div_load`=1 captures `div_in` into `div_pend` and sets `busy`.
  - A pending value is copied to `div_act` at the wrap edge, or on the next edge if `enable`=0. `busy` clears on that edge.
- Boundary cases:
  - Load while `busy`: the newer value overwrites `div_pend`; `busy` stays high. Only the last value is applied.
  - Load in the same cycle as a wrap: the value is applied at the following wrap, not the current one.
  - Load with `div_in` 0 or 1: accepted and stored; the clamp applies when the value is used.
  - `enable` falls mid-period: `cnt`→0, `clkout`→0, `tick`→0 on the next edge.
  - `enable` rises: counting restarts from `cnt`=0 with no tick; the first tick occurs after a full period.
- Reset, asynchronous at any time including mid-period or with a load pending:
  - `cnt`=0, `clkout`=0, `tick`=0, `busy`=0.
  - `div_act`=`div_pend`=`DEFAULT_DIV`.

## Timing
- Output latency is one clock from counter state. All outputs are flops; no combinational path from any input to any output.
- Period is exactly D `clkin` cycles. `tick` has period D and is high for one cycle.
- `busy` rises one edge after `div_load`. Worst-case `busy` duration is D_old cycles.
- No output glitches on divisor change. The period in progress always completes with the old D.

## Configuration
- `DIVIDER_SIM_EN` defined:
  - Effective divisor is forced to 8, ignoring `div_act`, so simulations stay short.
  - The handshake, `busy` and `div_act` update still behave normally and remain observable.
- `DIVIDER_SIM_EN` undefined: effective divisor is the clamped `div_act`. This is the synthesis build.

## Test plan
- Reset, then `div_load` with 4, `enable`=1, macro off → after the first wrap, `clkout` repeats 0,0,1,1, and `tick` is high every 4th cycle when `cnt`=0.
- Load 5 → `clkout` low 2 cycles, high 3 cycles, period 5. Load 0 → behaves as D=2 (0,1 alternating, tick every 2 cycles).
- D=10 with `cnt`=3: load 6, then load 7 two cycles later → the current period finishes at 10 cycles, then periods are 7; `busy` is high from one edge after the first load until the wrap.
- Drop `enable` at `cnt`=5 → next edge `cnt`=0, `clkout`=0, pending load applied, `busy`=0. Re-enable → first `tick` after exactly D cycles.
- Assert `reset` mid-period with a load pending → immediately `clkout`=0, `tick`=0, `busy`=0. After release, the divisor equals `DEFAULT_DIV` (verified with `DEFAULT_DIV`=6 override).
- `DIVIDER_SIM_EN` defined, load 1000 → period 8, `clkout` 0,0,0,0,1,1,1,1; `busy` still clears at the wrap.
